compute_unit_pipe: RTL and testbench
====================================

Name: compute_unit_pipe

Overview:
Parametrised register-file compute unit. Executes fixed-format instructions (opcode, target, two sources, or immediate) against an internal register file. Uses valid/ready handshakes on both the instruction and result sides, with a 2-stage pipeline and full backpressure. Replaces the single-cycle 8-bit compute unit under the top-level wrapper, with wider data, configurable register count, flags and illegal-opcode reporting.

Parameters:
DATA_W, 8, register and result width (>=4)
NUM_REGS, 16, register count (power of 2, 2..16)
RID_W, $clog2(NUM_REGS), register-id width (localparam, derived)
INSTR_W, 4+3*RID_W, instruction width (localparam; 16 at defaults)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  unit can accept this cycle
instruction  in  INSTR_W  [top 4]=opcode, then tgt, src0, src1 (RID_W each, MSB to LSB)
res_valid  out  1  result held on res_* outputs
res_ready  in  1  consumer accepts result
res_data  out  DATA_W  written/read value
res_reg_id  out  RID_W  register id the result refers to
res_zero  out  1  res_data == 0
res_carry  out  1  carry/borrow/shift-out
res_err  out  1  illegal opcode

Behaviour:
- Reset is asynchronous and active-low on rstn. While rstn=0: all registers=0; S1 empty; res_valid/res_data/res_reg_id/res_zero/res_carry/res_err=0. Reset asserted mid-operation discards all in-flight instructions and the held result.
- Accept: when instr_valid && instr_ready at an edge. instr_ready = !(res_valid && !res_ready). It is combinational and does not depend on instr_valid.
- S1 (accept edge): latch opcode, ids, and imm = low 2*RID_W bits of instruction, zero-extended or truncated to DATA_W.
- S2 (next edge, only if not stalled): read src0/src1 from the register file, compute, write the target, and load the res_* registers. Latency = 2 edges from accept to res_valid. Throughput = 1 per cycle.
- RAW hazards: none. A writeback at edge N is visible to the instruction computing at edge N+1. Back-to-back dependent instructions need no stall.
- Stall: when res_valid && !res_ready, S1 and S2 hold and the register file is not written. When res_ready=1 the held result is consumed and the next result may load at the same edge.
- Opcodes:
  - 0 NOP: no write, no result, slot consumed.
  - 1 LOAD: tgt=imm.
  - 2 ADD: carry = carry-out.
  - 3 SUB: src0-src1, carry = borrow.
  - 4 AND.
  - 5 OR.
  - 6 NOT: bitwise ~src0.
  - 7 XOR.
  - 8 SHL: src0<<1, carry = src0[MSB].
  - 9 SHR: logical shift right by 1, carry = src0[0].
  - A READ: no write; res_data = src0, res_reg_id = src0 id.
  - B-F illegal: no write; res_valid=1, res_err=1, res_data=0, res_reg_id=tgt.
- Arithmetic is modulo 2^DATA_W. carry=0 for every opcode not listed with a carry. res_zero is computed from res_data.
- tgt == src: the source is read before the write, so the new value is written (e.g. ADD r1,r1,r1 doubles r1).

Decomposition:
- Package cu_pkg holds:
  - opcode localparams (OP_NOP..OP_READ);
  - the opcode field position;
  - a function legal_op(opcode).
- Sub-module cu_alu is purely combinational: (opcode, a, b, imm) -> (result, carry, wr_en, err), parametrised on DATA_W. The pipeline registers, handshake and register file stay in compute_unit_pipe.

Test Plan:
- Reset then LOAD r1,0x05; LOAD r2,0x03; ADD r3,r1,r2 back-to-back with res_ready=1 -> results at cycles 2,3,4: (r1,0x05), (r2,0x03), (r3,0x08,z=0,c=0).
- LOAD r4,0xFF; LOAD r5,0x01; ADD r6,r4,r5 -> res_data=0x00, zero=1, carry=1. Then SUB r7,r5,r4 -> 0x02, carry=1.
- res_ready=0 for 3 cycles while 3 instructions are offered -> instr_ready=0 after the first result is held. Results stay stable, no register write. On release, all 3 results appear in order, none lost or duplicated.
- Opcode 0xC -> res_err=1, res_data=0. A following READ of the target shows its prior value unchanged. NOP -> no res_valid pulse.
- SHL r1 (0x81) -> 0x02, carry=1. SHR -> 0x40, carry=1. NOT 0x0F -> 0xF0.
- rstn pulsed low mid-stream with 2 instructions in flight -> all outputs 0 immediately (asynchronously). READ r3 after release returns 0x00.

Source files
------------

// File: rtl/cu_pkg.sv
// Purpose: shared opcode encoding and instruction-field helpers for the compute unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: OP_* opcode values, opcode field width/position, legal_op() check.
package cu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_LOAD = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h3;
  localparam logic [OP_W-1:0] OP_AND  = 4'h4;
  localparam logic [OP_W-1:0] OP_OR   = 4'h5;
  localparam logic [OP_W-1:0] OP_NOT  = 4'h6;
  localparam logic [OP_W-1:0] OP_XOR  = 4'h7;
  localparam logic [OP_W-1:0] OP_SHL  = 4'h8;
  localparam logic [OP_W-1:0] OP_SHR  = 4'h9;
  localparam logic [OP_W-1:0] OP_READ = 4'hA;

  // The opcode occupies the top OP_W bits, directly above the three register ids.
  function automatic int op_lsb(input int rid_w);
    return 3 * rid_w;
  endfunction

  // Encodings above OP_READ are unassigned and reported as errors.
  function automatic logic legal_op(input logic [OP_W-1:0] op);
    return (op <= OP_READ);
  endfunction

endpackage

// File: rtl/cu_alu.sv
// Purpose: combinational ALU for the compute unit (result, carry, write enable, error).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller decides when the outputs are consumed.
// Ports: op/a/b/imm in; result, carry, wr_en (target write), err (illegal opcode) out.
module cu_alu
  import cu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              wr_en,
  output logic              err
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // One extra bit captures carry-out for ADD and borrow for SUB.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    wr_en  = 1'b0;
    err    = !legal_op(op);
    case (op)
      OP_LOAD: begin result = imm;               wr_en = 1'b1; end
      OP_ADD:  begin result = sum[DATA_W-1:0];   carry = sum[DATA_W];  wr_en = 1'b1; end
      OP_SUB:  begin result = diff[DATA_W-1:0];  carry = diff[DATA_W]; wr_en = 1'b1; end
      OP_AND:  begin result = a & b;             wr_en = 1'b1; end
      OP_OR:   begin result = a | b;             wr_en = 1'b1; end
      OP_NOT:  begin result = ~a;                wr_en = 1'b1; end
      OP_XOR:  begin result = a ^ b;             wr_en = 1'b1; end
      OP_SHL:  begin result = {a[DATA_W-2:0], 1'b0}; carry = a[DATA_W-1]; wr_en = 1'b1; end
      OP_SHR:  begin result = {1'b0, a[DATA_W-1:1]}; carry = a[0];        wr_en = 1'b1; end
      OP_READ: begin result = a; end
      default: begin result = '0; end  // NOP and illegal encodings: no write
    endcase
  end

endmodule

// File: rtl/compute_unit_pipe.sv
// Purpose: register-file compute unit, 2-stage pipeline (S1 decode latch, S2 execute/writeback).
// Latency: result valid 2 edges after accept (accept edge included); 1 instruction/cycle.
// Backpressure: a held, unconsumed result freezes S1, S2 and the register file; instr_ready drops.
// Ports: clk, rstn (async active-low); instr_valid/instr_ready/instruction in;
//        res_valid/res_ready with res_data, res_reg_id, res_zero, res_carry, res_err out.
module compute_unit_pipe
  import cu_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int NUM_REGS = 16,
  localparam int RID_W    = $clog2(NUM_REGS),
  localparam int INSTR_W  = OP_W + 3 * RID_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instruction,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DATA_W-1:0]  res_data,
  output logic [RID_W-1:0]   res_reg_id,
  output logic               res_zero,
  output logic               res_carry,
  output logic               res_err
);

  localparam int OP_LSB = op_lsb(RID_W);

  logic [DATA_W-1:0] rf [NUM_REGS];

  logic              s1_vld;
  logic [OP_W-1:0]   s1_op;
  logic [RID_W-1:0]  s1_tgt;
  logic [RID_W-1:0]  s1_src0;
  logic [RID_W-1:0]  s1_src1;
  logic [DATA_W-1:0] s1_imm;

  logic [2*RID_W-1:0] imm_raw;
  logic [DATA_W-1:0]  imm_ext;
  logic               stall;
  logic               s1_has_res;

  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_wr_en;
  logic              alu_err;

  assign stall       = res_valid && !res_ready;
  assign instr_ready = !stall;

  // Immediate is the two source-id fields taken together, resized to the data width.
  assign imm_raw = instruction[2*RID_W-1:0];
  assign imm_ext = DATA_W'(imm_raw);

  // NOP consumes its slot but never produces a result.
  assign s1_has_res = s1_vld && (s1_op != OP_NOP);

  cu_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (s1_op),
    .a      (rf[s1_src0]),
    .b      (rf[s1_src1]),
    .imm    (s1_imm),
    .result (alu_result),
    .carry  (alu_carry),
    .wr_en  (alu_wr_en),
    .err    (alu_err)
  );

  // S1: decode latch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld  <= 1'b0;
      s1_op   <= OP_NOP;
      s1_tgt  <= '0;
      s1_src0 <= '0;
      s1_src1 <= '0;
      s1_imm  <= '0;
    end else if (!stall) begin
      s1_vld <= instr_valid;
      if (instr_valid) begin
        s1_op   <= instruction[INSTR_W-1:OP_LSB];
        s1_tgt  <= instruction[3*RID_W-1:2*RID_W];
        s1_src0 <= instruction[2*RID_W-1:RID_W];
        s1_src1 <= instruction[RID_W-1:0];
        s1_imm  <= imm_ext;
      end
    end
  end

  // S2 writeback. Sources are read combinationally in the same cycle, so the next
  // instruction sees this write and tgt==src uses the old value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf[i] <= '0;
      end
    end else if (!stall && s1_vld && alu_wr_en) begin
      rf[s1_tgt] <= alu_result;
    end
  end

  // S2 result register; reloads on the same edge the previous result is consumed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_reg_id <= '0;
      res_zero   <= 1'b0;
      res_carry  <= 1'b0;
      res_err    <= 1'b0;
    end else if (!stall) begin
      res_valid <= s1_has_res;
      if (s1_has_res) begin
        res_data   <= alu_result;
        res_zero   <= (alu_result == '0);
        res_carry  <= alu_carry;
        res_err    <= alu_err;
        res_reg_id <= (s1_op == OP_READ) ? s1_src0 : s1_tgt;
      end
    end
  end

endmodule

// File: tb/tb_compute_unit_pipe.sv
// Purpose: self-checking bench for compute_unit_pipe (directed cases + random stream vs. reference model).
// Latency: checks 2-edge accept-to-result timing on the first transactions.
// Backpressure: exercises held results with res_ready low, both directed and randomized.
module tb_compute_unit_pipe;

  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 16;
  localparam int RID_W    = 4;
  localparam int INSTR_W  = 16;

  logic               clk = 1'b0;
  logic               rstn = 1'b1;
  logic               instr_valid = 1'b0;
  logic               instr_ready;
  logic [INSTR_W-1:0] instruction = '0;
  logic               res_valid;
  logic               res_ready = 1'b1;
  logic [DATA_W-1:0]  res_data;
  logic [RID_W-1:0]   res_reg_id;
  logic               res_zero;
  logic               res_carry;
  logic               res_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  compute_unit_pipe #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_reg_id  (res_reg_id),
    .res_zero    (res_zero),
    .res_carry   (res_carry),
    .res_err     (res_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Result record: {err, carry, zero, reg_id, data}
  function automatic logic [31:0] pack(input logic [3:0] id, input logic [7:0] d,
                                       input logic c, input logic e);
    return {17'b0, e, c, (d == 8'h00), id, d};
  endfunction

  logic [31:0] res_obs;
  assign res_obs = {17'b0, res_err, res_carry, res_zero, res_reg_id, res_data};

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] t,
                                      input logic [3:0] a, input logic [3:0] b);
    return {op, t, a, b};
  endfunction

  function automatic logic [15:0] ld(input logic [3:0] t, input logic [7:0] imm);
    return {4'h1, t, imm};
  endfunction

  // ---------------- reference model: sequential ISA semantics ----------------
  logic [7:0]  mrf [NUM_REGS];
  logic [31:0] expq[$];
  logic [31:0] got_log[$];

  task automatic model_exec(input logic [15:0] i);
    logic [3:0] op = i[15:12];
    logic [3:0] t  = i[11:8];
    logic [3:0] s0 = i[7:4];
    logic [3:0] s1 = i[3:0];
    int a = int'(mrf[s0]);
    int b = int'(mrf[s1]);
    int r = 0;
    logic c = 1'b0;
    case (op)
      4'h0: return;
      4'h1: r = int'(i[7:0]);
      4'h2: begin r = (a + b) % 256; c = (a + b) > 255; end
      4'h3: begin r = (a - b + 256) % 256; c = a < b; end
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = 255 - a;
      4'h7: r = a ^ b;
      4'h8: begin r = (a * 2) % 256; c = a > 127; end
      4'h9: begin r = a / 2; c = (a % 2) == 1; end
      4'hA: begin expq.push_back(pack(s0, 8'(a), 1'b0, 1'b0)); return; end
      default: begin expq.push_back(pack(t, 8'h00, 1'b0, 1'b1)); return; end
    endcase
    mrf[t] = 8'(r);
    expq.push_back(pack(t, 8'(r), c, 1'b0));
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) mrf[i] = 8'h00;
    expq.delete();
  endtask

  // Monitor: inputs change only at posedge+1, so negedge sees the values the next edge uses.
  always @(negedge clk) begin
    if (rstn) begin
      if (res_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_res", {31'b0, res_valid}, 32'd0);
        end else begin
          chk("res", res_obs, expq[0]);
          if (res_ready) begin
            void'(expq.pop_front());
            got_log.push_back(res_obs);
          end
        end
      end
      if (instr_valid && instr_ready) model_exec(instruction);
    end
  end

  // ---------------- drivers ----------------
  task automatic issue(input logic [15:0] i);
    logic took = 1'b0;
    instr_valid = 1'b1;
    instruction = i;
    for (int n = 0; n < 200 && !took; n++) begin
      @(negedge clk);
      took = instr_ready;
      @(posedge clk);
      #1;
    end
    instr_valid = 1'b0;
    if (!took) chk("accept_timeout", {31'b0, instr_ready}, 32'd1);
  endtask

  task automatic drain();
    res_ready = 1'b1;
    for (int n = 0; n < 50 && expq.size() != 0; n++) @(negedge clk);
    chk("drain", expq.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] last(input int back);
    return got_log[got_log.size() - 1 - back];
  endfunction

  logic rnd_on = 1'b0;

  initial begin
    model_reset();
    #1 rstn = 1'b0;
    #2;
    chk("rst_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_obs", res_obs, 32'd0);
    chk("rst_ready", {31'b0, instr_ready}, 32'd1);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back loads and a dependent add: 2-edge latency, 1/cycle.
    issue(ld(4'd1, 8'h05));
    chk("lat_s1_only", {31'b0, res_valid}, 32'd0);
    issue(ld(4'd2, 8'h03));
    chk("t1_r1", res_obs, pack(4'd1, 8'h05, 1'b0, 1'b0));
    chk("t1_r1_vld", {31'b0, res_valid}, 32'd1);
    issue(ins(4'h2, 4'd3, 4'd1, 4'd2));
    chk("t1_r2", res_obs, pack(4'd2, 8'h03, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    chk("t1_add", res_obs, pack(4'd3, 8'h08, 1'b0, 1'b0));
    drain();

    // Carry / borrow / wrap to zero.
    issue(ld(4'd4, 8'hFF));
    issue(ld(4'd5, 8'h01));
    issue(ins(4'h2, 4'd6, 4'd4, 4'd5));
    issue(ins(4'h3, 4'd7, 4'd5, 4'd4));
    drain();
    chk("add_wrap", last(1), pack(4'd6, 8'h00, 1'b1, 1'b0));
    chk("sub_borrow", last(0), pack(4'd7, 8'h02, 1'b1, 1'b0));

    // Backpressure: two accepted, third blocked while result held.
    res_ready = 1'b0;
    issue(ld(4'd8, 8'h3C));
    issue(ins(4'h2, 4'd9, 4'd8, 4'd8));
    chk("stall_rdy", {31'b0, instr_ready}, 32'd0);
    instr_valid = 1'b1;
    instruction = ins(4'hA, 4'd0, 4'd8, 4'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_hold_rdy", {31'b0, instr_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    issue(ins(4'hA, 4'd0, 4'd8, 4'd0));
    drain();
    chk("stall_a", last(2), pack(4'd8, 8'h3C, 1'b0, 1'b0));
    chk("stall_b", last(1), pack(4'd9, 8'h78, 1'b0, 1'b0));
    chk("stall_c", last(0), pack(4'd8, 8'h3C, 1'b0, 1'b0));

    // Illegal opcode leaves target untouched; NOP produces nothing.
    issue(ins(4'hC, 4'd3, 4'd1, 4'd2));
    issue(ins(4'hA, 4'd0, 4'd3, 4'd0));
    drain();
    chk("illegal", last(1), pack(4'd3, 8'h00, 1'b0, 1'b1));
    chk("illegal_keep", last(0), pack(4'd3, 8'h08, 1'b0, 1'b0));
    issue(ins(4'h0, 4'd1, 4'd2, 4'd3));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("nop_quiet", {31'b0, res_valid}, 32'd0);
    end
    @(posedge clk);
    #1;

    // Shifts and NOT.
    issue(ld(4'd1, 8'h81));
    issue(ins(4'h8, 4'd2, 4'd1, 4'd0));
    issue(ins(4'h9, 4'd3, 4'd1, 4'd0));
    issue(ld(4'd4, 8'h0F));
    issue(ins(4'h6, 4'd5, 4'd4, 4'd0));
    issue(ins(4'h2, 4'd1, 4'd1, 4'd1));
    drain();
    chk("shl", last(4), pack(4'd2, 8'h02, 1'b1, 1'b0));
    chk("shr", last(3), pack(4'd3, 8'h40, 1'b1, 1'b0));
    chk("not", last(1), pack(4'd5, 8'hF0, 1'b0, 1'b0));
    chk("self_add", last(0), pack(4'd1, 8'h02, 1'b1, 1'b0));

    // Random stream with random backpressure; every result scored by the monitor.
    rnd_on = 1'b1;
    fork
      begin
        for (int k = 0; k < 400; k++) begin
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
          end else begin
            issue(16'($urandom));
          end
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          res_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    // Asynchronous reset with two instructions in flight.
    issue(ld(4'd3, 8'h77));
    issue(ins(4'h2, 4'd3, 4'd3, 4'd3));
    chk("pre_rst_vld", {31'b0, res_valid}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", {31'b0, res_valid}, 32'd0);
    chk("arst_obs", res_obs, 32'd0);
    chk("arst_ready", {31'b0, instr_ready}, 32'd1);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk);
    #1;
    issue(ins(4'hA, 4'd0, 4'd3, 4'd0));
    drain();
    chk("post_rst_read", last(0), pack(4'd3, 8'h00, 1'b0, 1'b0));
    chk("queue_empty", expq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
